// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Turns the binary timer count into packed BCD digits for the 7-segment path.
// Values above 10^DIGITS-1 saturate to all nines and raise overflow.
module binary_to_bcd_seq #(
    parameter int unsigned BIN_WIDTH = 13,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd_out,
    output logic                    overflow
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int unsigned CMP_W   = (BIN_WIDTH > 64) ? BIN_WIDTH : 64;
    localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BCD_W   = 4 * DIGITS;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    state_t               state, state_n;
    logic [BIN_WIDTH-1:0] shift_reg, shift_n;
    logic [BCD_W-1:0]     scratch, scratch_n;
    logic [BCD_W-1:0]     adj;
    logic [CNT_W-1:0]     count, count_n;
    logic                 ovf_pend, ovf_pend_n;
    logic [BCD_W-1:0]     bcd_n;
    logic                 overflow_n;
    logic                 done_n;
    logic [CMP_W-1:0]     bin_ext;
    logic [CMP_W-1:0]     max_ext;
    logic [BCD_W-1:0]     nines;

    assign busy = (state == SHIFT);

    // Widened operands for the range check, and the saturation pattern.
    always_comb begin
        bin_ext = CMP_W'(bin_in);
        max_ext = CMP_W'(MAX_VAL);
        nines   = {DIGITS{4'h9}};
    end

    // Add-3 correction on every digit >= 5, using only pre-shift values.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update for IDLE accept / SHIFT / completion.
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        scratch_n  = scratch;
        count_n    = count;
        ovf_pend_n = ovf_pend;
        bcd_n      = bcd_out;
        overflow_n = overflow;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shift_n    = bin_in;
                    scratch_n  = '0;
                    count_n    = CNT_W'(BIN_WIDTH);
                    ovf_pend_n = (bin_ext > max_ext);
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                // Top scratch bit is dropped; only matters in the saturated case.
                scratch_n = {adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
                shift_n   = shift_reg << 1;
                count_n   = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    bcd_n      = ovf_pend ? nines : {adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
                    overflow_n = ovf_pend;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            ovf_pend  <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            shift_reg <= shift_n;
            scratch   <= scratch_n;
            count     <= count_n;
            ovf_pend  <= ovf_pend_n;
            bcd_out   <= bcd_n;
            overflow  <= overflow_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [12:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    logic        start3;
    logic [12:0] bin_in3;
    logic        busy3;
    logic        done3;
    logic [11:0] bcd_out3;
    logic        overflow3;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];

    logic [15:0] held_bcd = '0;
    logic        held_ovf = 1'b0;

    binary_to_bcd_seq #(.BIN_WIDTH(13), .DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    // Three-digit instance: 13-bit inputs can exceed 999, exercising saturation.
    binary_to_bcd_seq #(.BIN_WIDTH(13), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin_in(bin_in3),
        .busy(busy3), .done(done3), .bcd_out(bcd_out3), .overflow(overflow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop on done, otherwise outputs must hold the last result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_bcd = '0;
                held_ovf = 1'b0;
            end else if (done) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending conversion", cyc);
                end else begin
                    e = sb.pop_front();
                    if (bcd_out !== e.bcd) begin
                        fails++;
                        $display("FAIL bcd_out: got %h, required %h", bcd_out, e.bcd);
                    end
                    tests++;
                    if (overflow !== e.ovf) begin
                        fails++;
                        $display("FAIL overflow: got %b, required %b", overflow, e.ovf);
                    end
                    tests++;
                    if (cyc - e.acc != 13) begin
                        fails++;
                        $display("FAIL latency: got %0d cycles, required 13", cyc - e.acc);
                    end
                    held_bcd = e.bcd;
                    held_ovf = e.ovf;
                end
            end else begin
                tests++;
                if (bcd_out !== held_bcd || overflow !== held_ovf) begin
                    fails++;
                    $display("FAIL hold: got %h/%b, required %h/%b at cycle %0d",
                             bcd_out, overflow, held_bcd, held_ovf, cyc);
                end
            end
        end
    end

    task automatic issue(input logic [12:0] v, input logic [15:0] eb, input logic eo);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        e.bcd  = eb;
        e.ovf  = eo;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL timeout: %0d conversions pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check1(input string name, input logic [15:0] got, input logic [15:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic conv3(input logic [12:0] v, input logic [11:0] eb, input logic eo);
        int i;
        @(negedge clk);
        start3  = 1'b1;
        bin_in3 = v;
        @(negedge clk);
        start3 = 1'b0;
        for (i = 0; i < 40; i++) begin
            if (done3) break;
            @(negedge clk);
        end
        check1("dut3_done", 16'(done3), 16'd1);
        check1("dut3_bcd", 16'(bcd_out3), 16'(eb));
        check1("dut3_ovf", 16'(overflow3), 16'(eo));
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        bin_in  = '0;
        start3  = 1'b0;
        bin_in3 = '0;
        repeat (3) @(negedge clk);
        check1("reset_bcd", bcd_out, 16'h0000);
        check1("reset_ovf", 16'(overflow), 16'd0);
        check1("reset_busy", 16'(busy), 16'd0);
        check1("reset_done", 16'(done), 16'd0);
        #1 rst = 1'b0;

        // Zero, with busy width measured.
        issue(13'd0, 16'h0000, 1'b0);
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            @(negedge clk);
        end
        check1("busy_cycles", 16'(n), 16'd13);
        wait_idle();

        issue(13'd1,    16'h0001, 1'b0); wait_idle();
        issue(13'd59,   16'h0059, 1'b0); wait_idle();
        issue(13'd600,  16'h0600, 1'b0); wait_idle();
        issue(13'd5999, 16'h5999, 1'b0); wait_idle();
        issue(13'd8191, 16'h8191, 1'b0); wait_idle();
        issue(13'd42,   16'h0042, 1'b0); wait_idle();

        // Saturation on the three-digit instance, then recovery.
        conv3(13'd8191, 12'h999, 1'b1);
        conv3(13'd42,   12'h042, 1'b0);
        conv3(13'd999,  12'h999, 1'b0);

        // Start during busy is ignored.
        issue(13'd123, 16'h0123, 1'b0);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bin_in = 13'd777;
        @(negedge clk);
        start = 1'b0;
        check1("busy_kept", 16'(busy), 16'd1);
        wait_idle();
        repeat (16) @(negedge clk);

        // Back-to-back with start held high; bin_in changes in the done cycle.
        begin
            exp_t e;
            @(negedge clk);
            start  = 1'b1;
            bin_in = 13'd45;
            e.bcd = 16'h0045; e.ovf = 1'b0; e.acc = cyc + 1;
            sb.push_back(e);
            n = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) break;
                n++;
            end
            check1("b2b_first_done", 16'(done), 16'd1);
            bin_in = 13'd99;
            e.bcd = 16'h0099; e.ovf = 1'b0; e.acc = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
            wait_idle();
        end

        // Asynchronous reset mid-conversion.
        issue(13'd5999, 16'h5999, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check1("arst_bcd", bcd_out, 16'h0000);
        check1("arst_ovf", 16'(overflow), 16'd0);
        check1("arst_busy", 16'(busy), 16'd0);
        check1("arst_done", 16'(done), 16'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);

        issue(13'd7, 16'h0007, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
